// File: rtl/core_feeder_pkg.sv
// Shared types and helpers for the core_feeder slice: FSM state encoding,
// default operand width / burst length, and the FIFO level-width helper.
package core_feeder_pkg;

  localparam int DW_DEF    = 5;
  localparam int BURST_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/core_feeder_fifo.sv
// feeder_fifo: single-clock show-ahead FIFO with a registered occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module feeder_fifo
  import core_feeder_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DW-1:0]               wdata,
  output logic [DW-1:0]               rdata,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/core_feeder.sv
// core_feeder: buffers operands and issues them to the sum core as BURST-word bursts,
// then waits for core_done plus one idle cycle. Define CORE_FEEDER_TIMEOUT_EN for the err watchdog.
module core_feeder
  import core_feeder_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = 8,
  parameter int BURST   = BURST_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic [DW-1:0]               s_data,
  output logic                        s_ready,
  output logic                        core_in_valid,
  output logic [DW-1:0]               core_in,
  input  logic                        core_done,
  output logic                        busy,
  output logic [level_w(DEPTH)-1:0]   fifo_level
`ifdef CORE_FEEDER_TIMEOUT_EN
  ,
  output logic                        err
`endif
);

  localparam int LW = level_w(DEPTH);
  localparam int CW = $clog2(BURST + 1);

  if (DEPTH < BURST || TIMEOUT < 1) begin : g_param_check
    $error("core_feeder: DEPTH must be >= BURST and TIMEOUT must be >= 1");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign busy    = (state != IDLE);

  // A burst only starts once all BURST words are buffered, so SEND never starves.
  assign pop = ((state == IDLE) && (fifo_level >= LW'(BURST))) ||
               ((state == SEND) && (cnt < CW'(BURST)) && !empty);

  feeder_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

`ifdef CORE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      core_in_valid <= 1'b0;
      core_in       <= '0;
`ifdef CORE_FEEDER_TIMEOUT_EN
      wdog          <= '0;
      err           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state         <= SEND;
            core_in       <= head;
            core_in_valid <= 1'b1;
            cnt           <= CW'(1);
          end
        end
        SEND: begin
          if (cnt < CW'(BURST)) begin
            core_in <= head;
            cnt     <= cnt + CW'(1);
          end else begin
            core_in_valid <= 1'b0;
            core_in       <= '0;
            cnt           <= '0;
            state         <= WAIT;
`ifdef CORE_FEEDER_TIMEOUT_EN
            wdog          <= '0;
`endif
          end
        end
        WAIT: begin
          if (core_done) begin
            state <= GAP;
`ifdef CORE_FEEDER_TIMEOUT_EN
          end else if (wdog == TW'(TIMEOUT - 1)) begin
            state <= GAP;
            err   <= 1'b1;
          end else begin
            wdog <= wdog + TW'(1);
`endif
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_feeder.sv
// Self-checking bench for core_feeder: queue-based behavioural model compared every cycle,
// plus directed literal checks. Honours CORE_FEEDER_TIMEOUT_EN when defined.
module tb_core_feeder;

  localparam int DW      = 5;
  localparam int DEPTH   = 8;
  localparam int BURST   = 3;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          core_done = 1'b0;
  logic          s_ready;
  logic          core_in_valid;
  logic [DW-1:0] core_in;
  logic          busy;
  logic [3:0]    fifo_level;
`ifdef CORE_FEEDER_TIMEOUT_EN
  logic          err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core_feeder #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .BURST   (BURST),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .core_in_valid (core_in_valid),
    .core_in       (core_in),
    .core_done     (core_done),
    .busy          (busy),
    .fifo_level    (fifo_level)
`ifdef CORE_FEEDER_TIMEOUT_EN
    ,
    .err           (err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a word queue plus the burst/wait/gap timeline.
  int q[$];
  bit armed = 1'b0;
  bit m_vld = 1'b0;
  int m_data = 0;
  int m_issued = 0;
  bit m_wait = 1'b0;
  bit m_gap = 1'b0;
  int m_wd = 0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    bit do_push;
    if (!rst_n) begin
      q.delete();
      m_vld = 0; m_data = 0; m_issued = 0;
      m_wait = 0; m_gap = 0; m_wd = 0; m_err = 0;
      armed = 1;
    end else begin
      do_push = s_valid && (q.size() < DEPTH);
      if (m_gap) begin
        m_gap = 0;
      end else if (m_wait) begin
        if (core_done) begin
          m_wait = 0; m_gap = 1;
        end
`ifdef CORE_FEEDER_TIMEOUT_EN
        else if (m_wd == TIMEOUT - 1) begin
          m_wait = 0; m_gap = 1; m_err = 1;
        end else begin
          m_wd++;
        end
`endif
      end else if (m_vld) begin
        if (m_issued < BURST) begin
          m_data = q.pop_front();
          m_issued++;
        end else begin
          m_vld = 0; m_data = 0; m_wait = 1; m_wd = 0;
        end
      end else if (q.size() >= BURST) begin
        m_vld = 1; m_data = q.pop_front(); m_issued = 1;
      end
      if (do_push) q.push_back(int'(s_data));
    end
  end

  // Per-cycle comparison and burst-word monitor.
  int seen[$];
  always @(negedge clk) begin
    if (armed) begin
      chk("core_in_valid", core_in_valid, m_vld);
      chk("core_in", core_in, m_data);
      chk("busy", busy, m_vld || m_wait || m_gap);
      chk("fifo_level", fifo_level, q.size());
      chk("s_ready", s_ready, q.size() < DEPTH);
`ifdef CORE_FEEDER_TIMEOUT_EN
      chk("err", err, m_err);
`endif
      if (core_in_valid === 1'b1) seen.push_back(int'(core_in));
    end
  end

  function automatic int seen_at(input int i);
    return (i < seen.size()) ? seen[i] : -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (core_in_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    tests++;
    if (core_in_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: core_in_valid=%b after 40 cycles, expected 1", name, core_in_valid);
    end
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_valid", core_in_valid, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 1);
    rst_n = 1'b1;

    // Burst of 4,9,17
    s_valid = 1'b1;
    s_data = 5'd4;  step();
    s_data = 5'd9;  step();
    s_data = 5'd17; step();
    s_valid = 1'b0;
    wait_valid("t1_start");
    chk("t1_busy_in_burst", busy, 1);
    repeat (BURST) step();
    chk("t1_w0", seen_at(0), 4);
    chk("t1_w1", seen_at(1), 9);
    chk("t1_w2", seen_at(2), 17);
    chk("t1_busy_wait", busy, 1);
    chk("t1_level", fifo_level, 0);
    pulse_done();
    chk("t1_busy_gap", busy, 1);
    step();
    chk("t1_idle", busy, 0);

    // Two words do not start a burst; the third does
    s_valid = 1'b1;
    s_data = 5'd5; step();
    s_data = 5'd6; step();
    s_valid = 1'b0;
    repeat (4) step();
    chk("t2_no_burst", seen.size(), 3);
    chk("t2_idle", busy, 0);
    chk("t2_level", fifo_level, 2);
    s_valid = 1'b1;
    s_data = 5'd7; step();
    s_valid = 1'b0;
    chk("t2_not_yet", core_in_valid, 0);
    step();
    chk("t2_start", core_in_valid, 1);
    repeat (BURST) step();
    chk("t2_w0", seen_at(3), 5);
    chk("t2_w1", seen_at(4), 6);
    chk("t2_w2", seen_at(5), 7);
    pulse_done();
    repeat (2) step();

    // Nine words 10..18 with core_done low, then fill to full
    s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data = DW'(10 + i);
      step();
    end
    s_valid = 1'b0;
    step();
    chk("t3_level6", fifo_level, 6);
    chk("t3_b1_w0", seen_at(6), 10);
    chk("t3_b1_w2", seen_at(8), 12);
    s_valid = 1'b1;
    s_data = 5'd19; step();
    s_data = 5'd20; step();
    chk("t3_level8", fifo_level, 8);
    chk("t3_not_ready", s_ready, 0);
    s_data = 5'd30; step();
    s_valid = 1'b0;
    chk("t3_full_hold", fifo_level, 8);
    chk("t3_still_wait", busy, 1);
    pulse_done();
    chk("t3_gap_no_valid", core_in_valid, 0);
    wait_valid("t3_second");
    repeat (BURST) step();
    chk("t3_b2_w0", seen_at(9), 13);
    chk("t3_b2_w1", seen_at(10), 14);
    chk("t3_b2_w2", seen_at(11), 15);
    chk("t3_level5", fifo_level, 5);

    // Simultaneous push/pop at level 5 during SEND
    s_valid = 1'b1;
    s_data = 5'd21; step();
    s_valid = 1'b0;
    pulse_done();
    wait_valid("t4_start");
    chk("t4_level_a", fifo_level, 5);
    s_valid = 1'b1;
    s_data = 5'd22; step();
    chk("t4_level_b", fifo_level, 5);
    s_data = 5'd23; step();
    chk("t4_level_c", fifo_level, 5);
    s_valid = 1'b0;
    step();
    chk("t4_w0", seen_at(12), 16);
    chk("t4_w1", seen_at(13), 17);
    chk("t4_w2", seen_at(14), 18);

    // Reset after the second word of a burst
    pulse_done();
    wait_valid("t5_start");
    step();
    chk("t5_w0", seen_at(15), 19);
    chk("t5_w1", seen_at(16), 20);
    rst_n = 1'b0;
    step();
    chk("t5_valid", core_in_valid, 0);
    chk("t5_core_in", core_in, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_two_valids", seen.size(), 17);
    rst_n = 1'b1;
    step();

    // WAIT with core_done never asserted
    s_valid = 1'b1;
    s_data = 5'd1; step();
    s_data = 5'd2; step();
    s_data = 5'd3; step();
    s_valid = 1'b0;
    wait_valid("t6_start");
    repeat (BURST) step();
`ifdef CORE_FEEDER_TIMEOUT_EN
    repeat (TIMEOUT - 1) step();
    chk("t6_err_before", err, 0);
    step();
    chk("t6_err_set", err, 1);
    chk("t6_gap", busy, 1);
    step();
    chk("t6_idle", busy, 0);
    repeat (3) step();
    chk("t6_err_sticky", err, 1);
    rst_n = 1'b0;
    step();
    chk("t6_err_cleared", err, 0);
    rst_n = 1'b1;
`else
    repeat (30) step();
    chk("t6_wait_forever", busy, 1);
    chk("t6_no_valid", core_in_valid, 0);
    pulse_done();
    step();
    chk("t6_idle", busy, 0);
`endif
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "timeout");
  end

endmodule
